// File: rtl/pe_pkg.sv
// pe_pkg: shared FSM states, brick width and beat shift constants for the operand feeder
package pe_pkg;
  localparam int LANES_DEF = 16;
  localparam int BRICK_W = 2;
  localparam logic [3:0] SHIFT_LL = 4'd0;
  localparam logic [3:0] SHIFT_MID = 4'd2;
  localparam logic [3:0] SHIFT_HH = 4'd4;
  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_B3} feeder_state_e;
  function automatic logic [3:0] beat_shift(input feeder_state_e s);
    return s == S_B3 ? SHIFT_HH : (s == S_B1 || s == S_B2) ? SHIFT_MID : SHIFT_LL;
  endfunction
endpackage

// File: rtl/brick_slicer.sv
// brick_slicer: picks the low or high 2-bit slice of every 4-bit lane
module brick_slicer
  import pe_pkg::*;
#(parameter int LANES = LANES_DEF) (
  input  logic [4*LANES-1:0]       i_data,
  input  logic                     i_hi,
  output logic [BRICK_W*LANES-1:0] o_brick
);
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign o_brick[BRICK_W*k +: BRICK_W] = i_hi ? i_data[4*k+2 +: 2] : i_data[4*k +: 2];
  end
endmodule

// File: rtl/pe_operand_feeder.sv
// pe_operand_feeder: splits 2/4-bit operand vectors into registered 2-bit brick beats for a PE.
// Optional FEEDER_BEAT_CNT_EN adds a live 16-bit consumed-beat counter on o_beat_cnt.
module pe_operand_feeder
  import pe_pkg::*;
#(parameter int LANES = LANES_DEF) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [4*LANES-1:0]       i_act,
  input  logic [4*LANES-1:0]       i_wgt,
  input  logic                     i_mode4,
  input  logic                     i_A_signed,
  input  logic                     i_W_signed,
  output logic [BRICK_W*LANES-1:0] o_activation,
  output logic [BRICK_W*LANES-1:0] o_weight,
  output logic                     o_A_signed,
  output logic                     o_W_signed,
  output logic [3:0]               o_shift_amount,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_last,
  output logic [15:0]              o_beat_cnt
);
  feeder_state_e r_state, w_nxt_state;
  logic [4*LANES-1:0] r_act, r_wgt, w_src_act, w_src_wgt;
  logic [BRICK_W*LANES-1:0] w_act_brick, w_wgt_brick;
  logic r_mode4, r_as, r_ws, r_valid, r_last;
  logic w_accept, w_consume, w_mode4, w_as, w_ws, w_a_hi, w_w_hi;
  assign o_valid = r_valid;
  assign o_last = r_last;
  assign o_ready = !i_rst && (r_state == S_IDLE || (r_valid && i_ready && r_last));
  assign w_accept = i_valid && o_ready;
  assign w_consume = r_valid && i_ready;
  // On accept the first beat is sliced straight from the inputs so it is valid next cycle
  always_comb begin
    w_nxt_state = w_accept ? S_B0 : r_last ? S_IDLE : feeder_state_e'(r_state + 3'd1);
    w_src_act = w_accept ? i_act : r_act;
    w_src_wgt = w_accept ? i_wgt : r_wgt;
    w_mode4 = w_accept ? i_mode4 : r_mode4;
    w_as = w_accept ? i_A_signed : r_as;
    w_ws = w_accept ? i_W_signed : r_ws;
    w_a_hi = w_nxt_state == S_B1 || w_nxt_state == S_B3;
    w_w_hi = w_nxt_state == S_B2 || w_nxt_state == S_B3;
  end
  brick_slicer #(.LANES(LANES)) u_act_slicer (.i_data(w_src_act), .i_hi(w_a_hi), .o_brick(w_act_brick));
  brick_slicer #(.LANES(LANES)) u_wgt_slicer (.i_data(w_src_wgt), .i_hi(w_w_hi), .o_brick(w_wgt_brick));
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_last <= 1'b0;
      o_activation <= '0;
      o_weight <= '0;
      o_shift_amount <= '0;
      o_A_signed <= 1'b0;
      o_W_signed <= 1'b0;
      r_act <= '0;
      r_wgt <= '0;
      r_mode4 <= 1'b0;
      r_as <= 1'b0;
      r_ws <= 1'b0;
    end else if (w_accept || w_consume) begin
      r_state <= w_nxt_state;
      r_valid <= w_nxt_state != S_IDLE;
      r_last <= w_nxt_state != S_IDLE && (!w_mode4 || w_nxt_state == S_B3);
      o_activation <= w_act_brick;
      o_weight <= w_wgt_brick;
      o_shift_amount <= w_mode4 ? beat_shift(w_nxt_state) : SHIFT_LL;
      o_A_signed <= w_as && (!w_mode4 || w_a_hi);
      o_W_signed <= w_ws && (!w_mode4 || w_w_hi);
      if (w_accept) begin
        r_act <= i_act;
        r_wgt <= i_wgt;
        r_mode4 <= i_mode4;
        r_as <= i_A_signed;
        r_ws <= i_W_signed;
      end
    end
  end
`ifdef FEEDER_BEAT_CNT_EN
  logic [15:0] r_beat_cnt;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_beat_cnt <= '0;
    else if (w_consume) r_beat_cnt <= r_beat_cnt + 16'd1;
  end
  assign o_beat_cnt = r_beat_cnt;
`else
  assign o_beat_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_pe_operand_feeder.sv
// tb_pe_operand_feeder: directed-vector bench for pe_operand_feeder with immediate assertions
module tb_pe_operand_feeder;
  logic clk = 1'b0, rst = 1'b1;
  logic i_valid = 1'b0, i_ready = 1'b1, i_mode4 = 1'b0, i_as = 1'b0, i_ws = 1'b0;
  logic [63:0] i_act = '0, i_wgt = '0;
  logic [31:0] o_act, o_wgt;
  logic o_ready, o_as, o_ws, o_valid, o_last;
  logic [3:0] o_shift;
  logic [15:0] o_cnt;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  pe_operand_feeder dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_act(i_act), .i_wgt(i_wgt), .i_mode4(i_mode4),
    .i_A_signed(i_as), .i_W_signed(i_ws),
    .o_activation(o_act), .o_weight(o_wgt), .o_A_signed(o_as), .o_W_signed(o_ws),
    .o_shift_amount(o_shift), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_beat_cnt(o_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input string tag, input logic [31:0] a, input logic [31:0] w,
                      input logic [3:0] sh, input logic as, input logic ws,
                      input logic last, input logic rdy);
    chk({tag, ".valid"}, 64'(o_valid), 64'd1);
    chk({tag, ".act"}, 64'(o_act), 64'(a));
    chk({tag, ".wgt"}, 64'(o_wgt), 64'(w));
    chk({tag, ".shift"}, 64'(o_shift), 64'(sh));
    chk({tag, ".asgn"}, 64'(o_as), 64'(as));
    chk({tag, ".wsgn"}, 64'(o_ws), 64'(ws));
    chk({tag, ".last"}, 64'(o_last), 64'(last));
    chk({tag, ".ready"}, 64'(o_ready), 64'(rdy));
  endtask
  task automatic all_zero(input string tag);
    chk({tag, ".valid"}, 64'(o_valid), 64'd0);
    chk({tag, ".last"}, 64'(o_last), 64'd0);
    chk({tag, ".ready"}, 64'(o_ready), 64'd0);
    chk({tag, ".act"}, 64'(o_act), 64'd0);
    chk({tag, ".wgt"}, 64'(o_wgt), 64'd0);
    chk({tag, ".shift"}, 64'(o_shift), 64'd0);
    chk({tag, ".sgn"}, 64'({o_as, o_ws}), 64'd0);
  endtask
  task automatic offer(input logic [3:0] a, input logic [3:0] w, input logic m4,
                       input logic as, input logic ws);
    i_valid = 1'b1;
    i_act = {16{a}};
    i_wgt = {16{w}};
    i_mode4 = m4;
    i_as = as;
    i_ws = ws;
  endtask
  initial begin
    #2;
    all_zero("reset");
    chk("reset.cnt", 64'(o_cnt), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_reset.ready", 64'(o_ready), 64'd1);
    chk("post_reset.valid", 64'(o_valid), 64'd0);
    // mode2: one beat, flags passed straight through
    offer(4'h3, 4'h1, 1'b0, 1'b1, 1'b0);
    tick();
    i_valid = 1'b0;
    beat("m2", 32'hFFFFFFFF, 32'h55555555, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("m2.done", 64'(o_valid), 64'd0);
    // mode4: act B (L=11,H=10), wgt 6 (L=10,H=01), A signed
    offer(4'hB, 4'h6, 1'b1, 1'b1, 1'b0);
    tick();
    i_valid = 1'b0;
    beat("m4.b0", 32'hFFFFFFFF, 32'hAAAAAAAA, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    beat("m4.b1", 32'hAAAAAAAA, 32'hAAAAAAAA, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    beat("m4.b2", 32'hFFFFFFFF, 32'h55555555, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    beat("m4.b3", 32'hAAAAAAAA, 32'h55555555, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("m4.done", 64'(o_valid), 64'd0);
    // stall in B1: act 9 (L=01,H=10), wgt E (L=10,H=11), W signed
    offer(4'h9, 4'hE, 1'b1, 1'b0, 1'b1);
    tick();
    i_valid = 1'b0;
    beat("st.b0", 32'h55555555, 32'hAAAAAAAA, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    offer(4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("st.hold%0d", i), 32'hAAAAAAAA, 32'hAAAAAAAA, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    #1;
    beat("st.b1", 32'hAAAAAAAA, 32'hAAAAAAAA, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    beat("st.b2", 32'h55555555, 32'hFFFFFFFF, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    beat("st.b3", 32'hAAAAAAAA, 32'hFFFFFFFF, 4'd4, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("st.done", 64'(o_valid), 64'd0);
    // back-to-back mode4 vectors
    offer(4'hB, 4'h6, 1'b1, 1'b1, 1'b0);
    tick();
    offer(4'h9, 4'hE, 1'b1, 1'b0, 1'b1);
    beat("bb.v1b0", 32'hFFFFFFFF, 32'hAAAAAAAA, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    beat("bb.v1b1", 32'hAAAAAAAA, 32'hAAAAAAAA, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    beat("bb.v1b2", 32'hFFFFFFFF, 32'h55555555, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    beat("bb.v1b3", 32'hAAAAAAAA, 32'h55555555, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    i_valid = 1'b0;
    beat("bb.v2b0", 32'h55555555, 32'hAAAAAAAA, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    beat("bb.v2b1", 32'hAAAAAAAA, 32'hAAAAAAAA, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    beat("bb.v2b2", 32'h55555555, 32'hFFFFFFFF, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    beat("bb.v2b3", 32'hAAAAAAAA, 32'hFFFFFFFF, 4'd4, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("bb.done", 64'(o_valid), 64'd0);
    // asynchronous reset in B2
    offer(4'hB, 4'h6, 1'b1, 1'b1, 1'b1);
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    chk("rs.inB2", 64'(o_shift), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    all_zero("rs.async");
    chk("rs.cnt", 64'(o_cnt), 64'd0);
    tick();
    all_zero("rs.held");
    rst = 1'b0;
    #1;
    chk("rs.ready", 64'(o_ready), 64'd1);
    chk("rs.idle", 64'(o_valid), 64'd0);
    offer(4'h3, 4'h1, 1'b0, 1'b0, 1'b1);
    tick();
    i_valid = 1'b0;
    beat("rs.m2", 32'hFFFFFFFF, 32'h55555555, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("rs.after1", 64'(o_valid), 64'd0);
    tick();
    chk("rs.after2", 64'(o_valid), 64'd0);
`ifdef FEEDER_BEAT_CNT_EN
    chk("cnt.one", 64'(o_cnt), 64'd1);
    offer(4'hB, 4'h6, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 65534; i++) tick();
    chk("cnt.max", 64'(o_cnt), 64'hFFFF);
    tick();
    chk("cnt.wrap", 64'(o_cnt), 64'd0);
    i_valid = 1'b0;
`else
    chk("cnt.tied", 64'(o_cnt), 64'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pe_operand_feeder.md
PE_OPERAND_FEEDER -- requirements
Module: pe_operand_feeder

Interface
REQ-001 SHALL have parameter LANES, default 16, meaning number of 2-bit brick lanes per output word.
REQ-002 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_valid  input  1  an operand vector is offered.
REQ-005 SHALL have port o_ready  output  1  the feeder accepts the offered vector this cycle.
REQ-006 SHALL have port i_act  input  4*LANES  LANES packed 4-bit activations; element k is i_act[4k+3:4k].
REQ-007 SHALL have port i_wgt  input  4*LANES  LANES packed 4-bit weights, same packing as i_act.
REQ-008 SHALL have port i_mode4  input  1  0 = 2-bit precision, 1 = 4-bit precision.
REQ-009 SHALL have port i_A_signed / i_W_signed  input  1 each  element signedness of the activation and weight.
REQ-010 SHALL have port o_activation / o_weight  output  2*LANES each  brick words for the PE; lane k is bits [2k+1:2k].
REQ-011 SHALL have port o_A_signed / o_W_signed  output  1 each  per-beat brick signedness.
REQ-012 SHALL have port o_shift_amount  output  4  left shift the PE applies to the beat's sum.
REQ-013 SHALL have ports o_valid (output, 1, beat present), i_ready (input, 1, PE consumes beat) and o_last (output, 1, final beat of the vector).

Function
REQ-014 SHALL transfer an input vector only on a cycle with i_valid && o_ready, capturing i_act, i_wgt, i_mode4 and the sign flags into internal registers.
REQ-015 SHALL assert o_ready only in IDLE, or on the cycle the final beat is consumed (o_valid && i_ready && o_last), giving back-to-back vectors with no bubble.
REQ-016 SHALL implement states IDLE, B0, B1, B2, B3: IDLE->B0 on accept; B0->IDLE (mode2) or B0->B1 (mode4) on beat consumption; B1->B2->B3 on consumption; B3->IDLE, or B3->B0 when a new vector is accepted in the same cycle.
REQ-017 SHALL drive all beat outputs from registers; the first beat is valid the cycle after acceptance.
REQ-018 SHALL hold every beat output stable while o_valid && !i_ready.
REQ-019 SHALL emit in mode2 one beat: low slices of A and W, the input sign flags, shift 0, and o_last=1.
REQ-020 SHALL emit in mode4 four beats in order (A slice, W slice, shift): (L,L,0), (H,L,2), (L,H,2), (H,H,4); o_last=1 only on the fourth beat.
REQ-021 SHALL mark a low slice unsigned and a high slice signed only when its element's input flag is 1.
REQ-022 SHALL make o_ready low and capture nothing while a beat other than the final one is outstanding.

Reset
REQ-023 SHALL on i_rst, at any time, force state IDLE, and force o_valid, o_last, o_ready, o_activation, o_weight, o_shift_amount and both sign outputs to 0.
REQ-024 SHALL discard any partially sequenced vector on reset, with no further beats emitted for it.
REQ-025 SHALL drive o_ready high on the first clock edge after i_rst deasserts.

Configuration
REQ-026 SHALL, with FEEDER_BEAT_CNT_EN defined, add output o_beat_cnt (16 bits): reset to 0, incremented on each consumed beat, wrapping from 0xFFFF to 0.
REQ-027 SHALL, without FEEDER_BEAT_CNT_EN, still present o_beat_cnt but tie it to constant 0 with no counter logic.

Structure
REQ-028 SHALL take the state enum, brick width (2), shift constants (0/2/4) and LANES default from shared package pe_pkg.
REQ-029 SHALL use one combinational sub-module, brick_slicer, which selects the low or high 2-bit slice of every lane from a hi/lo select.

Verification
REQ-030 SHALL cover: mode2 vector with i_act lanes=4'h3, i_wgt lanes=4'h1, i_ready=1 -> one beat, o_activation=32'hFFFFFFFF, o_weight=32'h55555555, shift 0, o_last=1.
REQ-031 SHALL cover: mode4 vector with all act=4'hB, wgt=4'h6, signed A=1, W=0 -> four beats, shifts 0,2,2,4; A-slice 2'b11/2'b10; o_A_signed 0,1,0,1; o_W_signed always 0.
REQ-032 SHALL cover: i_ready low for 3 cycles during beat B1 -> outputs stable for those cycles, o_ready=0, no beat lost or repeated.
REQ-033 SHALL cover: two mode4 vectors offered back-to-back with i_ready=1 -> 8 consecutive beats, o_ready high on the B3 cycle only, no idle cycle.
REQ-034 SHALL cover: i_rst pulsed asynchronously during B2 -> all outputs 0 immediately; after release, a new mode2 vector yields exactly one beat.
REQ-035 SHALL cover: with FEEDER_BEAT_CNT_EN defined, counter preloaded by 65535 consumed beats plus one more -> o_beat_cnt=0.
